// File: rtl/gen_ram_wren_pkg.sv
// Shared constants and helpers for the three-RAM line-buffer sequencers.
// Also imported by the read-side sequencer.
package gen_ram_wren_pkg;

  localparam int NUM_RAMS = 3;

  localparam logic [1:0] RAM_A = 2'd0;
  localparam logic [1:0] RAM_B = 2'd1;
  localparam logic [1:0] RAM_C = 2'd2;

  // Round-robin step A -> B -> C -> A; code 3 never occurs but maps to A.
  function automatic logic [1:0] mod3_inc(input logic [1:0] sel);
    logic [1:0] nxt;
    if (sel == RAM_C || sel == 2'd3) nxt = RAM_A;
    else                             nxt = sel + 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/gen_ram_occupancy.sv
// Complete-line occupancy counter with oldest-line RAM select.
// Shared between the write and read sides of the line buffer.
module gen_ram_occupancy
  import gen_ram_wren_pkg::*;
(
  input  logic       clk,
  input  logic       sclr,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] lines_full,
  output logic [1:0] rd_sel,
  output logic       line_rdy,
  output logic       full
);

  logic dec_eff;
  logic inc_eff;

  // A release with nothing buffered is ignored; a fill when full is only
  // legal if a release lands in the same cycle.
  assign dec_eff = dec & (lines_full != 2'd0);
  assign inc_eff = inc & (~full | dec_eff);

  always_ff @(posedge clk) begin
    if (sclr) begin
      lines_full <= 2'd0;
      rd_sel     <= RAM_A;
    end else begin
      case ({inc_eff, dec_eff})
        2'b10:   lines_full <= lines_full + 2'd1;
        2'b01:   lines_full <= lines_full - 2'd1;
        default: lines_full <= lines_full;
      endcase
      if (dec_eff) rd_sel <= mod3_inc(rd_sel);
    end
  end

  assign line_rdy = (lines_full != 2'd0);
  assign full     = (lines_full == 2'(NUM_RAMS));

endmodule

// File: rtl/gen_ram_wren.sv
// Write-side sequencer: steers the incoming word stream into RAM A/B/C one
// line at a time and stalls upstream when every RAM holds an unread line.
module gen_ram_wren
  import gen_ram_wren_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              din_valid,
  input  logic              rd_line_done,
  output logic              rama_wren,
  output logic              ramb_wren,
  output logic              ramc_wren,
  output logic [1:0]        wr_sel,
  output logic [1:0]        rd_sel,
  output logic [ADDR_W-1:0] word_cnt,
  output logic [1:0]        lines_full,
  output logic              line_rdy,
  output logic              wr_stall,
  output logic              line_end,
  output logic              overflow
);

  logic accept;
  logic line_done;

  assign accept    = din_valid & ~wr_stall;
  assign line_done = accept & (&word_cnt);

  assign rama_wren = accept & (wr_sel == RAM_A);
  assign ramb_wren = accept & (wr_sel == RAM_B);
  assign ramc_wren = accept & (wr_sel == RAM_C);

  // word_cnt wraps naturally at 2**ADDR_W, mirroring the downstream address.
  always_ff @(posedge clk) begin
    if (sclr) begin
      word_cnt <= '0;
      wr_sel   <= RAM_A;
      line_end <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept)    word_cnt <= word_cnt + ADDR_W'(1);
      if (line_done) wr_sel   <= mod3_inc(wr_sel);
      line_end <= line_done;
      if (din_valid & wr_stall) overflow <= 1'b1;
    end
  end

  gen_ram_occupancy u_occupancy (
    .clk        (clk),
    .sclr       (sclr),
    .inc        (line_done),
    .dec        (rd_line_done),
    .lines_full (lines_full),
    .rd_sel     (rd_sel),
    .line_rdy   (line_rdy),
    .full       (wr_stall)
  );

endmodule

// File: tb/tb_gen_ram_wren.sv
// Scoreboard bench for gen_ram_wren: directed scenarios plus random traffic
// against a word/line counting reference model.
module tb_gen_ram_wren;

  localparam int ADDR_W   = 5;
  localparam int LINE_LEN = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              sclr = 1'b0;
  logic              din_valid = 1'b0;
  logic              rd_line_done = 1'b0;
  logic              rama_wren, ramb_wren, ramc_wren;
  logic [1:0]        wr_sel, rd_sel, lines_full;
  logic [ADDR_W-1:0] word_cnt;
  logic              line_rdy, wr_stall, line_end, overflow;

  gen_ram_wren #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .sclr         (sclr),
    .din_valid    (din_valid),
    .rd_line_done (rd_line_done),
    .rama_wren    (rama_wren),
    .ramb_wren    (ramb_wren),
    .ramc_wren    (ramc_wren),
    .wr_sel       (wr_sel),
    .rd_sel       (rd_sel),
    .word_cnt     (word_cnt),
    .lines_full   (lines_full),
    .line_rdy     (line_rdy),
    .wr_stall     (wr_stall),
    .line_end     (line_end),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wren;
    int wr_sel;
    int rd_sel;
    int word_cnt;
    int lines_full;
    int line_rdy;
    int wr_stall;
    int line_end;
    int overflow;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: total words accepted since reset, lines written, lines read.
  int  m_words = 0;
  int  m_wl    = 0;
  int  m_rl    = 0;
  int  m_ovf   = 0;
  int  m_le    = 0;
  bit  m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit din, input bit rd, input bit clr);
    exp_t e;
    int   occ;
    bit   stall, acc, ldone, rel;
    @(posedge clk);
    #1;
    din_valid    = din;
    rd_line_done = rd;
    sclr         = clr;
    occ   = m_wl - m_rl;
    stall = (occ == 3);
    acc   = din && !stall;
    if (m_valid) begin
      e.wren       = acc ? (1 << (m_wl % 3)) : 0;
      e.wr_sel     = m_wl % 3;
      e.rd_sel     = m_rl % 3;
      e.word_cnt   = m_words % LINE_LEN;
      e.lines_full = occ;
      e.line_rdy   = (occ != 0);
      e.wr_stall   = stall;
      e.line_end   = m_le;
      e.overflow   = m_ovf;
      sb_q.push_back(e);
    end
    if (clr) begin
      m_words = 0; m_wl = 0; m_rl = 0; m_ovf = 0; m_le = 0;
      m_valid = 1'b1;
    end else begin
      ldone = acc && (m_words % LINE_LEN == LINE_LEN - 1);
      rel   = rd && (occ > 0);
      if (din && stall) m_ovf = 1;
      if (acc) m_words++;
      if (ldone) m_wl++;
      if (rel) m_rl++;
      m_le = ldone;
    end
  endtask

  task automatic run(input int n, input bit din);
    for (int i = 0; i < n; i++) cycle(din, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are stable at the falling edge; compare against the oldest entry.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("wren",       int'({ramc_wren, ramb_wren, rama_wren}), e.wren);
      chk("wr_sel",     int'(wr_sel),     e.wr_sel);
      chk("rd_sel",     int'(rd_sel),     e.rd_sel);
      chk("word_cnt",   int'(word_cnt),   e.word_cnt);
      chk("lines_full", int'(lines_full), e.lines_full);
      chk("line_rdy",   int'(line_rdy),   e.line_rdy);
      chk("wr_stall",   int'(wr_stall),   e.wr_stall);
      chk("line_end",   int'(line_end),   e.line_end);
      chk("overflow",   int'(overflow),   e.overflow);
      if (lines_full < 2'd3)
        chk("invariant", int'(wr_sel), (int'(rd_sel) + int'(lines_full)) % 3);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    // 1: one full line into A
    cycle(0, 0, 1);
    run(LINE_LEN, 1'b1);
    run(2, 1'b0);
    // 2: two more lines fill B and C, then stalled words overflow
    run(2 * LINE_LEN, 1'b1);
    run(4, 1'b1);
    // 3: release the oldest line, then resume writing into A
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    run(2, 1'b0);
    // 4: completion and release in the same cycle with one line buffered
    cycle(0, 0, 1);
    run(LINE_LEN, 1'b1);
    run(LINE_LEN - 1, 1'b1);
    cycle(1, 1, 0);
    run(2, 1'b0);
    // 5: release with nothing buffered is ignored
    cycle(0, 0, 1);
    cycle(0, 1, 0);
    run(2, 1'b0);
    // 6: reset partway into B
    cycle(0, 0, 1);
    run(LINE_LEN + 17, 1'b1);
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    run(2, 1'b0);
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit d, r, c;
      d = ($urandom_range(0, 99) < 75);
      r = ($urandom_range(0, 99) < 4);
      c = ($urandom_range(0, 999) < 3);
      if (c) d = 1'b0;
      cycle(d, r, c);
    end
    cycle(0, 0, 0);
    @(posedge clk);
    #6;
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
